hsst_tx_framer: RTL

HSST_TX_FRAMER -- requirements
Module: hsst_tx_framer

---
 rtl/hsst_tx_pkg.sv | 21 ++
 rtl/crc16_ccitt_d16.sv | 39 +++
 rtl/hsst_tx_framer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/hsst_tx_pkg.sv
// rtl/hsst_tx_pkg.sv - shared states and control words for the HSST TX framer
package hsst_tx_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SOF  = 3'd1,
        HDR  = 3'd2,
        PAY  = 3'd3,
        CRC  = 3'd4,
        EOF  = 3'd5
    } tx_state_t;

    localparam logic [15:0] K_IDLE   = 16'h50BC;
    localparam logic [15:0] K_SOF    = 16'h00FB;
    localparam logic [15:0] K_EOF    = 16'h00FD;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    localparam logic [1:0] KFLAG_CTRL = 2'b01;
    localparam logic [1:0] KFLAG_DATA = 2'b00;

endpackage

// File: rtl/crc16_ccitt_d16.sv
// rtl/crc16_ccitt_d16.sv - CRC-16-CCITT over 16-bit words, one word per cycle
module crc16_ccitt_d16
    import hsst_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [15:0] data,
    output logic [15:0] crc
);

    // Polynomial 0x1021, data consumed MSB first, unrolled across the word.
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [15:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 15; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0};
            if (fb) begin
                r = r ^ 16'h1021;
            end
        end
        return r;
    endfunction

    // Running CRC: clear wins over accumulate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= CRC_INIT;
        end else if (clr) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc_step(crc, data);
        end
    end

endmodule

// File: rtl/hsst_tx_framer.sv
// rtl/hsst_tx_framer.sv - FIFO-to-HSST framer (optional CRC word via HSST_TX_CRC_EN)
module hsst_tx_framer
    import hsst_tx_pkg::*;
#(
    parameter int BURST_LEN      = 256,
    parameter int RD_DEPTH_WIDTH = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tx_en,
    input  logic [15:0]             fifo_rd_data,
    input  logic                    fifo_rd_empty,
    input  logic [RD_DEPTH_WIDTH:0] fifo_rd_water_level,
    output logic                    fifo_rd_en,
    output logic [15:0]             tx_data,
    output logic [1:0]              tx_kchar,
    output logic [15:0]             frame_cnt,
    output logic                    underflow_err
);

    localparam int                      CNT_W       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0]        LAST_BEAT   = CNT_W'(BURST_LEN - 1);
    localparam logic [RD_DEPTH_WIDTH:0] START_LEVEL = (RD_DEPTH_WIDTH + 1)'(BURST_LEN);

    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] pay_cnt_q, pay_cnt_d;
    logic             rd_win_q, rd_win_d;
    logic             miss_q;
    logic [15:0]      tx_data_d;
    logic [1:0]       tx_kchar_d;
    logic [15:0]      pay_word;

`ifdef HSST_TX_CRC_EN
    logic        crc_clr;
    logic        crc_en;
    logic [15:0] crc_val;

    crc16_ccitt_d16 u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (crc_clr),
        .en    (crc_en),
        .data  (pay_word),
        .crc   (crc_val)
    );
`endif

    // The read window is a register; gating it with empty keeps reads off an empty FIFO.
    assign fifo_rd_en = rd_win_q & ~fifo_rd_empty;

    // Next state and next registered outputs. The read window runs one cycle ahead
    // of the word stream so the FIFO's read latency lands exactly in the PAY words.
    always_comb begin
        state_d    = state_q;
        pay_cnt_d  = pay_cnt_q;
        tx_data_d  = K_IDLE;
        tx_kchar_d = KFLAG_CTRL;
        pay_word   = miss_q ? 16'h0000 : fifo_rd_data;
`ifdef HSST_TX_CRC_EN
        crc_clr    = 1'b0;
        crc_en     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (tx_en && (fifo_rd_water_level >= START_LEVEL)) begin
                    state_d = SOF;
                end
            end
            SOF: begin
                tx_data_d = K_SOF;
                state_d   = HDR;
`ifdef HSST_TX_CRC_EN
                crc_clr   = 1'b1;
`endif
            end
            HDR: begin
                tx_data_d  = frame_cnt;
                tx_kchar_d = KFLAG_DATA;
                pay_cnt_d  = '0;
                state_d    = PAY;
            end
            PAY: begin
                tx_data_d  = pay_word;
                tx_kchar_d = KFLAG_DATA;
                pay_cnt_d  = pay_cnt_q + CNT_W'(1);
`ifdef HSST_TX_CRC_EN
                crc_en     = 1'b1;
                if (pay_cnt_q == LAST_BEAT) begin
                    state_d = CRC;
                end
`else
                if (pay_cnt_q == LAST_BEAT) begin
                    state_d = EOF;
                end
`endif
            end
`ifdef HSST_TX_CRC_EN
            CRC: begin
                tx_data_d  = crc_val;
                tx_kchar_d = KFLAG_DATA;
                state_d    = EOF;
            end
`endif
            EOF: begin
                tx_data_d = K_EOF;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        rd_win_d = (state_d == HDR) || ((state_d == PAY) && (pay_cnt_d != LAST_BEAT));
    end

    // State, read window and output registers; reset truncates any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pay_cnt_q     <= '0;
            rd_win_q      <= 1'b0;
            miss_q        <= 1'b0;
            tx_data       <= K_IDLE;
            tx_kchar      <= KFLAG_CTRL;
            underflow_err <= 1'b0;
        end else begin
            state_q       <= state_d;
            pay_cnt_q     <= pay_cnt_d;
            rd_win_q      <= rd_win_d;
            miss_q        <= rd_win_q & fifo_rd_empty;
            tx_data       <= tx_data_d;
            tx_kchar      <= tx_kchar_d;
            underflow_err <= underflow_err | (rd_win_q & fifo_rd_empty);
        end
    end

    // Completed-frame counter, bumped as EOF goes out; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= 16'h0000;
        end else if (state_q == EOF) begin
            frame_cnt <= frame_cnt + 16'h0001;
        end
    end

endmodule
